// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [31:0]             instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue: DEPTH-entry circular buffer with synchronous flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        head,
  output logic [CW-1:0] count
);

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  // Pointer and occupancy tracking; flush discards same-cycle push and pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= {PW{1'b0}};
      wr_ptr <= {PW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; stale contents are never observed because count gates validity.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC generation, credit-limited memory requests,
// in-order response buffering and redirect with stale-response discard.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int               DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid_in,
  input  logic [XLEN-1:0] redirect_pc_in,
  output logic            imem_req_out,
  output logic [XLEN-1:0] imem_addr_out,
  input  logic            imem_gnt_in,
  input  logic            imem_rvalid_in,
  input  logic [31:0]     imem_rdata_in,
  output logic            ifid_valid_out,
  input  logic            ifid_ready_in,
  output logic [XLEN-1:0] ifid_pc_out,
  output logic [XLEN-1:0] ifid_pc_plus_4_out,
  output logic [31:0]     ifid_instr_out
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   q_count;
  logic [XLEN-1:0] target;
  logic            credit;
  logic            fire;
  logic            resp;
  logic            drop;
  logic            q_push;
  logic            q_pop;
  entry_t          push_data;
  entry_t          head;

  // Handshake decode; a redirect blocks requests and queue traffic in its cycle.
  always_comb begin
    target       = redirect_pc_in & ~(XLEN'(3));
    credit       = ({1'b0, outstanding} + {1'b0, q_count}) < (CW + 1)'(DEPTH);
    imem_req_out = !rst && !redirect_valid_in && credit;
    fire         = imem_req_out && imem_gnt_in;
    resp         = imem_rvalid_in && (outstanding != {CW{1'b0}});
    drop         = resp && (drop_cnt != {CW{1'b0}});
    q_push       = resp && !drop && !redirect_valid_in;
    q_pop        = ifid_valid_out && ifid_ready_in && !redirect_valid_in;
    push_data    = '{pc: resp_pc, instr: imem_rdata_in};
  end

  // PC and in-flight bookkeeping; on redirect every still-outstanding request
  // becomes stale, so drop_cnt is simply what remains outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= {CW{1'b0}};
      drop_cnt    <= {CW{1'b0}};
    end else if (redirect_valid_in) begin
      fetch_pc    <= target;
      resp_pc     <= target;
      outstanding <= outstanding - CW'(resp);
      drop_cnt    <= outstanding - CW'(resp);
    end else begin
      fetch_pc    <= fire ? fetch_pc + XLEN'(4) : fetch_pc;
      resp_pc     <= q_push ? resp_pc + XLEN'(4) : resp_pc;
      outstanding <= outstanding + CW'(fire) - CW'(resp);
      drop_cnt    <= drop_cnt - CW'(drop);
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid_in),
    .push      (q_push),
    .push_data (push_data),
    .pop       (q_pop),
    .head      (head),
    .count     (q_count)
  );

  // IF/ID presentation; an empty queue shows a NOP at the next expected PC.
  always_comb begin
    imem_addr_out      = fetch_pc;
    ifid_valid_out     = (q_count != {CW{1'b0}});
    ifid_pc_out        = ifid_valid_out ? head.pc : resp_pc;
    ifid_pc_plus_4_out = ifid_pc_out + XLEN'(4);
    ifid_instr_out     = ifid_valid_out ? head.instr : NOP_INSTR;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model with configurable
// latency, scoreboard of expected instructions, directed and random scenarios.
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid_in;
  logic [31:0] redirect_pc_in;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_gnt_in;
  logic        imem_rvalid_in;
  logic [31:0] imem_rdata_in;
  logic        ifid_valid_out;
  logic        ifid_ready_in;
  logic [31:0] ifid_pc_out;
  logic [31:0] ifid_pc_plus_4_out;
  logic [31:0] ifid_instr_out;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst                (rst),
    .redirect_valid_in  (redirect_valid_in),
    .redirect_pc_in     (redirect_pc_in),
    .imem_req_out       (imem_req_out),
    .imem_addr_out      (imem_addr_out),
    .imem_gnt_in        (imem_gnt_in),
    .imem_rvalid_in     (imem_rvalid_in),
    .imem_rdata_in      (imem_rdata_in),
    .ifid_valid_out     (ifid_valid_out),
    .ifid_ready_in      (ifid_ready_in),
    .ifid_pc_out        (ifid_pc_out),
    .ifid_pc_plus_4_out (ifid_pc_plus_4_out),
    .ifid_instr_out     (ifid_instr_out)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } req_t;

  req_t        pend[$];
  logic [31:0] expq[$];
  logic [31:0] acc_log[$];
  int          cyc, epoch, lat, n_checks, n_fail;
  bit          gnt_rand;
  logic [31:0] exp_fetch, exp_out;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_pc4, s_instr;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  // One clock cycle: memory model drives, outputs are sampled and scored.
  task automatic step();
    req_t r;
    logic [31:0] e;
    imem_rvalid_in = 1'b0;
    imem_rdata_in  = 32'h0;
    if (redirect_valid_in && !rst) begin
      epoch++;
      expq.delete();
      exp_fetch = redirect_pc_in & ~32'h3;
      exp_out   = exp_fetch;
    end
    if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      imem_rvalid_in = 1'b1;
      imem_rdata_in  = instr_of(r.addr);
      if (r.epoch == epoch) expq.push_back(r.addr);
    end
    imem_gnt_in = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    s_req = imem_req_out;  s_addr = imem_addr_out;  s_valid = ifid_valid_out;
    s_pc = ifid_pc_out;    s_pc4 = ifid_pc_plus_4_out;  s_instr = ifid_instr_out;
    if (!rst) begin
      if (redirect_valid_in) begin
        n_checks++;
        if (s_req !== 1'b0) begin
          n_fail++; $display("FAIL req_in_redirect: got %b expected 0 (cycle %0d)", s_req, cyc);
        end
      end
      if (s_req === 1'b1 && imem_gnt_in) begin
        n_checks++;
        if (s_addr !== exp_fetch) begin
          n_fail++; $display("FAIL fetch_addr: got %h expected %h (cycle %0d)", s_addr, exp_fetch, cyc);
        end
        pend.push_back('{s_addr, cyc + lat, epoch});
        exp_fetch = exp_fetch + 32'd4;
      end
      if (s_valid === 1'b1 && ifid_ready_in && !redirect_valid_in) begin
        n_checks++;
        if (expq.size() == 0) begin
          n_fail++; $display("FAIL unexpected_output: got pc %h expected no valid (cycle %0d)", s_pc, cyc);
        end else begin
          e = expq.pop_front();
          if (s_pc !== exp_out || s_pc4 !== exp_out + 32'd4 || s_instr !== instr_of(exp_out)) begin
            n_fail++;
            $display("FAIL ifid_output: got pc %h pc4 %h instr %h expected pc %h pc4 %h instr %h (cycle %0d)",
                     s_pc, s_pc4, s_instr, exp_out, exp_out + 32'd4, instr_of(exp_out), cyc);
          end
          acc_log.push_back(s_pc);
          exp_out = exp_out + 32'd4;
        end
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_models();
    pend.delete();
    expq.delete();
    epoch++;
    exp_fetch = RESET_PC;
    exp_out   = RESET_PC;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid_in = 1'b0;
    clear_models();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_acc(input int n, input int budget, input string name);
    for (int i = 0; i < budget && acc_log.size() < n; i++) step();
    n_checks++;
    if (acc_log.size() < n) begin
      n_fail++; $display("FAIL %s_timeout: got %0d accepted expected %0d", name, acc_log.size(), n);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_checks++;
    if (s_req !== 1'b0 || s_addr !== RESET_PC || s_valid !== 1'b0 ||
        s_pc !== RESET_PC || s_pc4 !== RESET_PC + 32'd4 || s_instr !== NOP) begin
      n_fail++;
      $display("FAIL %s: got req %b addr %h valid %b pc %h pc4 %h instr %h expected 0 %h 0 %h %h %h",
               name, s_req, s_addr, s_valid, s_pc, s_pc4, s_instr, RESET_PC, RESET_PC, RESET_PC + 32'd4, NOP);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_models();
    step();
    step();
    check_reset_outputs("reset_values");
    rst = 1'b0;
    step();
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== RESET_PC) begin
      n_fail++; $display("FAIL first_request: got req %b addr %h expected 1 %h", s_req, s_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    do_reset();
    lat = 1; ifid_ready_in = 1'b1;
    acc_log.delete();
    for (int i = 0; i < 40; i++) begin
      step();
      if (i >= 3) begin
        n_checks++;
        if (s_valid !== 1'b1) begin
          n_fail++; $display("FAIL stream_valid: got %b expected 1 (step %0d)", s_valid, i);
        end
      end
    end
    n_checks++;
    if (acc_log.size() < 36 || acc_log[0] !== 32'h0 || acc_log[1] !== 32'h4 || acc_log[2] !== 32'h8) begin
      n_fail++; $display("FAIL stream_sequence: got %0d accepted expected >=36 starting 0,4,8", acc_log.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    lat = 1; ifid_ready_in = 1'b1;
    acc_log.delete();
    for (int i = 0; i < 20 && acc_log.size() < 2; i++) step();
    ifid_ready_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (s_valid !== 1'b1 || s_pc !== 32'h8 || s_instr !== instr_of(32'h8)) begin
        n_fail++; $display("FAIL stall_head: got valid %b pc %h expected 1 00000008 (step %0d)", s_valid, s_pc, i);
      end
    end
    n_checks++;
    if (s_req !== 1'b0) begin
      n_fail++; $display("FAIL stall_full_req: got %b expected 0", s_req);
    end
    ifid_ready_in = 1'b1;
    for (int i = 0; i < 20; i++) step();
    n_checks++;
    if (acc_log.size() < 18 || acc_log[2] !== 32'h8 || acc_log[3] !== 32'hC) begin
      n_fail++; $display("FAIL stall_release: got %0d accepted expected >=18 with 8,C after 0,4", acc_log.size());
    end
  endtask

  task automatic test_redirect_stale();
    do_reset();
    lat = 3; ifid_ready_in = 1'b1;
    for (int i = 0; i < 20 && pend.size() != 3; i++) step();
    n_checks++;
    if (pend.size() != 3) begin
      n_fail++; $display("FAIL stale_setup: got %0d outstanding expected 3", pend.size());
    end
    acc_log.delete();
    redirect_valid_in = 1'b1; redirect_pc_in = 32'h100;
    step();
    redirect_valid_in = 1'b0;
    step();
    n_checks++;
    if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h100) begin
      n_fail++; $display("FAIL redirect_next: got valid %b req %b addr %h expected 0 1 00000100", s_valid, s_req, s_addr);
    end
    wait_acc(2, 30, "stale");
    n_checks++;
    if (acc_log.size() == 0 || acc_log[0] !== 32'h100) begin
      n_fail++; $display("FAIL stale_first_pc: got %h expected 00000100", (acc_log.size() > 0) ? acc_log[0] : 32'hX);
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    lat = 1; ifid_ready_in = 1'b0;
    for (int i = 0; i < 20 && !(expq.size() == DEPTH - 1 && pend.size() > 0 && pend[0].due <= cyc); i++) step();
    n_checks++;
    if (!(expq.size() == DEPTH - 1 && pend.size() > 0)) begin
      n_fail++; $display("FAIL full_setup: got queue %0d pending %0d expected %0d 1", expq.size(), pend.size(), DEPTH - 1);
    end
    acc_log.delete();
    redirect_valid_in = 1'b1; redirect_pc_in = 32'h400;
    step();
    redirect_valid_in = 1'b0; ifid_ready_in = 1'b1;
    step();
    n_checks++;
    if (s_valid !== 1'b0) begin
      n_fail++; $display("FAIL full_flush: got valid %b expected 0", s_valid);
    end
    wait_acc(2, 20, "full");
    n_checks++;
    if (acc_log.size() == 0 || acc_log[0] !== 32'h400) begin
      n_fail++; $display("FAIL full_first_pc: got %h expected 00000400", (acc_log.size() > 0) ? acc_log[0] : 32'hX);
    end
  endtask

  task automatic test_align_wrap();
    do_reset();
    lat = 1; ifid_ready_in = 1'b1;
    repeat (5) step();
    acc_log.delete();
    redirect_valid_in = 1'b1; redirect_pc_in = 32'h203;
    step();
    redirect_valid_in = 1'b0;
    step();
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h200) begin
      n_fail++; $display("FAIL align_addr: got req %b addr %h expected 1 00000200", s_req, s_addr);
    end
    wait_acc(1, 20, "align");
    n_checks++;
    if (acc_log.size() == 0 || acc_log[0] !== 32'h200) begin
      n_fail++; $display("FAIL align_pc: got %h expected 00000200", (acc_log.size() > 0) ? acc_log[0] : 32'hX);
    end
    acc_log.delete();
    redirect_valid_in = 1'b1; redirect_pc_in = 32'hFFFF_FFFC;
    step();
    redirect_valid_in = 1'b0;
    wait_acc(2, 20, "wrap");
    n_checks++;
    if (acc_log.size() < 2 || acc_log[0] !== 32'hFFFF_FFFC || acc_log[1] !== 32'h0) begin
      n_fail++; $display("FAIL wrap_pc: got %0d accepted expected FFFFFFFC then 00000000", acc_log.size());
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    lat = 2; ifid_ready_in = 1'b1;
    repeat (6) step();
    acc_log.delete();
    redirect_valid_in = 1'b1; redirect_pc_in = 32'h300;
    step();
    redirect_pc_in = 32'h500;
    step();
    redirect_valid_in = 1'b0;
    wait_acc(3, 30, "b2b");
    n_checks++;
    if (acc_log.size() == 0 || acc_log[0] !== 32'h500) begin
      n_fail++; $display("FAIL b2b_first_pc: got %h expected 00000500", (acc_log.size() > 0) ? acc_log[0] : 32'hX);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    lat = 3; ifid_ready_in = 1'b0;
    repeat (6) step();
    rst = 1'b1;
    clear_models();
    step();
    step();
    check_reset_outputs("mid_reset_values");
    rst = 1'b0;
    step();
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== RESET_PC) begin
      n_fail++; $display("FAIL mid_reset_request: got req %b addr %h expected 1 %h", s_req, s_addr, RESET_PC);
    end
    lat = 1; ifid_ready_in = 1'b1;
    acc_log.delete();
    wait_acc(2, 20, "mid_reset");
    n_checks++;
    if (acc_log.size() < 2 || acc_log[0] !== RESET_PC || acc_log[1] !== RESET_PC + 32'd4) begin
      n_fail++; $display("FAIL mid_reset_seq: got %0d accepted expected %h then %h", acc_log.size(), RESET_PC, RESET_PC + 32'd4);
    end
  endtask

  task automatic test_random();
    do_reset();
    lat = 2; gnt_rand = 1'b1;
    acc_log.delete();
    for (int i = 0; i < 300; i++) begin
      ifid_ready_in     = ($urandom_range(0, 3) != 0);
      redirect_valid_in = ($urandom_range(0, 19) == 0);
      redirect_pc_in    = $urandom;
      step();
    end
    redirect_valid_in = 1'b0; gnt_rand = 1'b0; ifid_ready_in = 1'b1;
    n_checks++;
    if (acc_log.size() < 30) begin
      n_fail++; $display("FAIL random_progress: got %0d accepted expected >=30", acc_log.size());
    end
  endtask

  initial begin
    rst = 1'b1; redirect_valid_in = 1'b0; redirect_pc_in = 32'h0;
    imem_gnt_in = 1'b1; imem_rvalid_in = 1'b0; imem_rdata_in = 32'h0;
    ifid_ready_in = 1'b1; lat = 1; gnt_rand = 1'b0;
    cyc = 0; epoch = 0; n_checks = 0; n_fail = 0;
    exp_fetch = RESET_PC; exp_out = RESET_PC;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_stale();
    test_redirect_full();
    test_align_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
